// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES types and constants used by the key schedule and its S-box.
//   Contents:
//     word_t      32-bit key-schedule word
//     rkey_t      128-bit round key as four words, word 0 most significant
//     state_t     128-bit AES state as sixteen bytes
//     NR          number of AES-128 rounds
//     RCON[1:10]  round constants for key expansion
//     ks_state_t  key-schedule FSM encoding
//     rcon_of()   safe round-constant lookup (0 outside 1..10)
//     rot_word()  cyclic left byte rotation of a word
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [31:0]       word_t;
    typedef logic [0:3][31:0]  rkey_t;
    typedef logic [0:15][7:0]  state_t;

    localparam int NR = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_SERVE  = 2'd2
    } ks_state_t;

    // The word counter is evaluated every cycle, so the round number derived
    // from it can sit outside 1..10; those values map to zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            if (r == 4'(k)) begin
                v = RCON[k];
            end
        end
        return v;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
//   Combinational AES forward S-box (SubBytes on a single byte).
//   Ports:
//     in_byte   in  [7:0]  byte to substitute
//     out_byte  out [7:0]  substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry n of the table sits at index n (ascending packed range).
    localparam logic [0:255][7:0] SBOX_TBL = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX_TBL[in_byte];

endmodule

// File: rtl/inv_key_schedule.sv
// ---------------------------------------------------------------------------
// inv_key_schedule
//   AES-128 key expansion and round-key server for the decrypt datapath.
//   A key_load pulse captures the cipher key, the next 40 cycles expand one
//   word per cycle into a 44-word key store, then round keys are served
//   10 -> 0 over a valid/ready handshake, wrapping back to 10 for the next
//   block.
//
//   Optional macro KEY_SCHED_FWD_EN adds input fwd_mode (sampled on key_load);
//   when set, keys are served 0 -> 10 instead.
//
//   Ports:
//     clk         in   1           rising-edge clock
//     rst         in   1           synchronous active-high reset
//     cipher_key  in   rkey_t      cipher key, word 0 most significant
//     key_load    in   1           pulse: capture key and start expansion
//     key_ready   in   1           downstream accepts round_key
//     fwd_mode    in   1           (KEY_SCHED_FWD_EN only) forward order
//     round_key   out  rkey_t      current round key
//     key_valid   out  1           round_key valid
//     round_idx   out  4           round number of round_key
//     busy        out  1           expansion in progress
//     block_done  out  1           pulse after the last key of a block is taken
// ---------------------------------------------------------------------------
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  rkey_t       cipher_key,
    input  logic        key_load,
    input  logic        key_ready,
`ifdef KEY_SCHED_FWD_EN
    input  logic        fwd_mode,
`endif
    output rkey_t       round_key,
    output logic        key_valid,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        block_done
);

    localparam int NWORDS = NK * (NR + 1);

    // Handshake: a key transfers on any rising edge where key_valid and
    // key_ready are both high. key_valid is high exactly in SERVE and does not
    // depend on key_ready; while key_valid && !key_ready the offered key and
    // its index are held. key_load overrides any transfer in the same cycle.

    ks_state_t   state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [3:0]  round_idx_q, round_idx_d;
    logic        block_done_q, block_done_d;
    word_t       w_q [0:NWORDS-1];
    word_t       w_d [0:NWORDS-1];
    logic        fwd_sel;

`ifdef KEY_SCHED_FWD_EN
    logic        fwd_q, fwd_d;
    assign fwd_sel = fwd_q;
`else
    assign fwd_sel = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Expansion datapath: next word w[i] from w[i-1] and w[i-4]
    // ---------------------------------------------------------------------
    word_t prev_word;
    word_t back4_word;
    word_t rot_prev;
    word_t sub_prev;
    word_t temp_word;
    word_t new_word;

    assign prev_word  = w_q[i_q - 6'd1];
    assign back4_word = w_q[i_q - 6'd4];
    assign rot_prev   = rot_word(prev_word);

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_prev[31-8*b -: 8]),
            .out_byte (sub_prev[31-8*b -: 8])
        );
    end

    // i/4 is the round constant index on the first word of each round.
    assign temp_word = (i_q[1:0] == 2'b00)
                     ? (sub_prev ^ {rcon_of(i_q[5:2]), 24'h000000})
                     : prev_word;
    assign new_word  = back4_word ^ temp_word;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        round_idx_d  = round_idx_q;
        block_done_d = 1'b0;
        w_d          = w_q;
`ifdef KEY_SCHED_FWD_EN
        fwd_d        = fwd_q;
`endif

        if (key_load) begin
            for (int k = 0; k < 4; k++) begin
                w_d[k] = cipher_key[k];
            end
            i_d         = 6'd4;
            round_idx_d = 4'd0;
            state_d     = KS_EXPAND;
`ifdef KEY_SCHED_FWD_EN
            fwd_d       = fwd_mode;
`endif
        end else begin
            case (state_q)
                KS_EXPAND: begin
                    w_d[i_q] = new_word;
                    i_d      = i_q + 6'd1;
                    if (i_q == 6'(NWORDS - 1)) begin
                        state_d     = KS_SERVE;
                        round_idx_d = fwd_sel ? 4'd0 : 4'(NR);
                    end
                end
                KS_SERVE: begin
                    if (key_ready) begin
                        if (fwd_sel) begin
                            if (round_idx_q == 4'(NR)) begin
                                round_idx_d  = 4'd0;
                                block_done_d = 1'b1;
                            end else begin
                                round_idx_d  = round_idx_q + 4'd1;
                            end
                        end else begin
                            if (round_idx_q == 4'd0) begin
                                round_idx_d  = 4'(NR);
                                block_done_d = 1'b1;
                            end else begin
                                round_idx_d  = round_idx_q - 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE: key_ready is ignored until the next key_load.
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= KS_IDLE;
            i_q          <= 6'd0;
            round_idx_q  <= 4'd0;
            block_done_q <= 1'b0;
            for (int k = 0; k < NWORDS; k++) begin
                w_q[k] <= '0;
            end
`ifdef KEY_SCHED_FWD_EN
            fwd_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            round_idx_q  <= round_idx_d;
            block_done_q <= block_done_d;
            w_q          <= w_d;
`ifdef KEY_SCHED_FWD_EN
            fwd_q        <= fwd_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    rkey_t rk_sel;

    always_comb begin
        rk_sel = '0;
        for (int k = 0; k < 4; k++) begin
            rk_sel[k] = w_q[{round_idx_q, 2'b00} + 6'(k)];
        end
    end

    // The key is forced to zero outside SERVE so the downstream never sees a
    // stale or partially expanded key.
    assign round_key  = (state_q == KS_SERVE) ? rk_sel : '0;
    assign key_valid  = (state_q == KS_SERVE);
    assign busy       = (state_q == KS_EXPAND);
    assign round_idx  = round_idx_q;
    assign block_done = block_done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_inv_key_schedule
//   Directed bench for inv_key_schedule with FIPS-197 and all-zero key
//   vectors. Define KEY_SCHED_FWD_EN to also exercise forward ordering.
// ---------------------------------------------------------------------------
module tb_inv_key_schedule;
    import aes_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    rkey_t       cipher_key;
    logic        key_load;
    logic        key_ready;
    rkey_t       round_key;
    logic        key_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        block_done;
`ifdef KEY_SCHED_FWD_EN
    logic        fwd_mode;
`endif

    inv_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .cipher_key (cipher_key),
        .key_load   (key_load),
        .key_ready  (key_ready),
`ifdef KEY_SCHED_FWD_EN
        .fwd_mode   (fwd_mode),
`endif
        .round_key  (round_key),
        .key_valid  (key_valid),
        .round_idx  (round_idx),
        .busy       (busy),
        .block_done (block_done)
    );

    // ---------------- reference vectors ----------------
    localparam rkey_t FIPS_KEY = {32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    localparam rkey_t FIPS_R1  = {32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605};
    localparam rkey_t FIPS_R10 = {32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};
    localparam rkey_t ZERO_KEY = '0;
    localparam rkey_t ZERO_R10 = {32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e};

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input rkey_t k);
        cipher_key = k;
        key_load   = 1'b1;
        step();
        key_load   = 1'b0;
    endtask

    task automatic wait_serve(output int n);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key"},   round_key,  '0);
        check({tag, "_valid"}, key_valid,  1'b0);
        check({tag, "_idx"},   round_idx,  4'd0);
        check({tag, "_busy"},  busy,       1'b0);
        check({tag, "_done"},  block_done, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [3:0] e;
        int done_cnt;

        rst        = 1'b1;
        key_load   = 1'b0;
        key_ready  = 1'b0;
        cipher_key = '0;
`ifdef KEY_SCHED_FWD_EN
        fwd_mode   = 1'b0;
`endif
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // FIPS key, continuous ready: full block 10..0 then wrap to 10
        key_ready = 1'b1;
        load(FIPS_KEY);
        check("busy_after_load", busy, 1'b1);
        wait_serve(n);
        check("busy_cycles", n, 40);
        check("valid_after_expand", key_valid, 1'b1);

        for (int r = 10; r >= 0; r--) exp_q.push_back(4'(r));
        done_cnt = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("serve_idx", round_idx, e);
            check("serve_valid", key_valid, 1'b1);
            if (block_done) done_cnt++;
            if (e == 4'd10) check("fips_r10", round_key, FIPS_R10);
            if (e == 4'd1)  check("fips_r1",  round_key, FIPS_R1);
            if (e == 4'd0)  check("fips_r0",  round_key, FIPS_KEY);
            step();
        end
        check("done_in_block", done_cnt, 0);
        check("wrap_done", block_done, 1'b1);
        check("wrap_idx", round_idx, 4'd10);

        // Back-pressure: key and index hold while ready is low
        key_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("hold_idx", round_idx, 4'd10);
            check("hold_key", round_key, FIPS_R10);
            check("hold_valid", key_valid, 1'b1);
            check("hold_done", block_done, 1'b0);
        end
        key_ready = 1'b1;
        step();
        check("resume_idx", round_idx, 4'd9);

        // Reset while serving at idx 6
        repeat (3) step();
        check("pre_rst_idx", round_idx, 4'd6);
        rst = 1'b1;
        step();
        check_all_zero("mid_rst");
        rst = 1'b0;
        repeat (3) step();
        check_all_zero("post_rst");

        // Abort expansion after 20 cycles with the all-zero key
        load(FIPS_KEY);
        repeat (20) step();
        check("abort_busy", busy, 1'b1);
        load(ZERO_KEY);
        wait_serve(n);
        check("abort_busy_cycles", n, 40);
        check("zero_idx10", round_idx, 4'd10);
        check("zero_r10", round_key, ZERO_R10);
        repeat (10) step();
        check("zero_idx0", round_idx, 4'd0);

        // key_load together with the round-0 handshake: load wins, no done
        load(FIPS_KEY);
        check("ld_hs_done", block_done, 1'b0);
        check("ld_hs_valid", key_valid, 1'b0);
        check("ld_hs_busy", busy, 1'b1);
        check("ld_hs_key", round_key, '0);
        wait_serve(n);
        check("reload_cycles", n, 40);
        check("reload_r10", round_key, FIPS_R10);

`ifdef KEY_SCHED_FWD_EN
        // Forward order 0..10, done after round 10 is accepted
        fwd_mode = 1'b1;
        load(FIPS_KEY);
        fwd_mode = 1'b0;
        wait_serve(n);
        check("fwd_cycles", n, 40);
        check("fwd_idx0", round_idx, 4'd0);
        check("fwd_r0", round_key, FIPS_KEY);
        step();
        check("fwd_idx1", round_idx, 4'd1);
        check("fwd_r1", round_key, FIPS_R1);
        repeat (9) step();
        check("fwd_idx10", round_idx, 4'd10);
        check("fwd_r10", round_key, FIPS_R10);
        check("fwd_no_done", block_done, 1'b0);
        step();
        check("fwd_wrap_idx", round_idx, 4'd0);
        check("fwd_done", block_done, 1'b1);
`endif

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
